// File: rtl/hypot_seq_core.sv
// Sequential hypotenuse core: hyp = sqrt(x^2 + y^2) using one squaring cycle
// followed by a restoring bit-serial square root, one result bit per cycle.
module hypot_seq_core #(
    parameter int W     = 8,
    parameter int ROUND = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   hyp,
    output logic         exact,
    output logic         busy
);
    localparam int SW = 2 * W + 2;
    localparam int RW = W + 4;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SUM = 2'd1, ROOT = 2'd2, DONE = 2'd3} state_t;

    state_t          r_state;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_y;
    logic [SW-1:0]   r_s;
    logic [W:0]      r_root;
    logic [W+1:0]    r_rem;
    logic [CW-1:0]   r_cnt;
    logic            r_out_valid;
    logic [W:0]      r_hyp;
    logic            r_exact;

    logic [2*W-1:0]  w_xx;
    logic [2*W-1:0]  w_yy;
    logic [SW-1:0]   w_sum;
    logic [1:0]      w_pair;
    logic [RW-1:0]   w_rem_try;
    logic [RW-1:0]   w_trial;
    logic [RW-1:0]   w_diff;
    logic            w_ge;
    logic [W:0]      w_root_nx;
    logic [W+1:0]    w_rem_nx;
    logic [W:0]      w_hyp_nx;

    // Squared sum, one restoring root step over the current bit pair, and rounding
    always_comb begin
        w_xx      = r_x * r_x;
        w_yy      = r_y * r_y;
        w_sum     = {2'b00, w_xx} + {2'b00, w_yy};
        w_pair    = 2'(r_s >> {r_cnt, 1'b0});
        w_rem_try = {r_rem, w_pair};
        w_trial   = {1'b0, r_root, 2'b01};
        w_diff    = w_rem_try - w_trial;
        w_ge      = (w_rem_try >= w_trial);
        w_root_nx = {r_root[W-1:0], w_ge};
        if (w_ge) begin
            w_rem_nx = w_diff[W+1:0];
        end else begin
            w_rem_nx = w_rem_try[W+1:0];
        end
        // The remainder never exceeds 2*root, so W+2 bits always hold it
        if ((ROUND != 0) && (w_rem_nx > {1'b0, w_root_nx})) begin
            w_hyp_nx = w_root_nx + {{W{1'b0}}, 1'b1};
        end else begin
            w_hyp_nx = w_root_nx;
        end
    end

    // Control FSM, root datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_s         <= '0;
            r_root      <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_hyp       <= '0;
            r_exact     <= 1'b0;
        end else if (ena) begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_state <= SUM;
                    end
                end
                SUM: begin
                    r_s     <= w_sum;
                    r_root  <= '0;
                    r_rem   <= '0;
                    r_cnt   <= CW'(W);
                    r_state <= ROOT;
                end
                ROOT: begin
                    r_root <= w_root_nx;
                    r_rem  <= w_rem_nx;
                    if (r_cnt == '0) begin
                        r_hyp       <= w_hyp_nx;
                        r_exact     <= (w_rem_nx == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = ena & rst_n & (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign hyp       = r_hyp;
    assign exact     = r_exact;

endmodule

// File: tb/tb_hypot_seq_core.sv
// Directed bench for hypot_seq_core: W=8 floor/round and W=12 floor/round instances.
module tb_hypot_seq_core;
    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        out_ready;
    logic        iv8;
    logic [7:0]  x8;
    logic [7:0]  y8;
    logic        iv12;
    logic [11:0] x12;
    logic [11:0] y12;

    logic        ir0, ov0, ex0, bz0;
    logic [8:0]  h0;
    logic        ir1, ov1, ex1, bz1;
    logic [8:0]  h1;
    logic        ir2, ov2, ex2, bz2;
    logic [12:0] h2;
    logic        ir3, ov3, ex3, bz3;
    logic [12:0] h3;

    int total = 0;
    int bad   = 0;

    hypot_seq_core #(.W(8), .ROUND(0)) u0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(iv8), .in_ready(ir0),
        .x(x8), .y(y8), .out_valid(ov0), .out_ready(out_ready),
        .hyp(h0), .exact(ex0), .busy(bz0));
    hypot_seq_core #(.W(8), .ROUND(1)) u1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(iv8), .in_ready(ir1),
        .x(x8), .y(y8), .out_valid(ov1), .out_ready(out_ready),
        .hyp(h1), .exact(ex1), .busy(bz1));
    hypot_seq_core #(.W(12), .ROUND(1)) u2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(iv12), .in_ready(ir2),
        .x(x12), .y(y12), .out_valid(ov2), .out_ready(out_ready),
        .hyp(h2), .exact(ex2), .busy(bz2));
    hypot_seq_core #(.W(12), .ROUND(0)) u3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(iv12), .in_ready(ir3),
        .x(x12), .y(y12), .out_valid(ov3), .out_ready(out_ready),
        .hyp(h3), .exact(ex3), .busy(bz3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Present an operand pair and return at the falling edge after the accept edge
    task automatic start(input bit wide, input int a, input int b);
        int n;
        n = 0;
        if (wide) begin
            x12 = 12'(a); y12 = 12'(b); iv12 = 1'b1;
        end else begin
            x8 = 8'(a); y8 = 8'(b); iv8 = 1'b1;
        end
        while (!(wide ? ir2 : ir0) && n < 20) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        chk("accept_ready", int'(wide ? ir2 : ir0), 1);
        @(posedge clk); @(negedge clk);
        iv8  = 1'b0;
        iv12 = 1'b0;
    endtask

    task automatic wait_out(input bit wide, output int n);
        n = 0;
        while (!(wide ? ov2 : ov0) && n < 40) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
    endtask

    task automatic run8(input int a, input int b, input int eh0, input int eh1, input int eex);
        int n;
        start(1'b0, a, b);
        wait_out(1'b0, n);
        chk("lat8", n, 10);
        chk("hyp_floor8", int'(h0), eh0);
        chk("hyp_round8", int'(h1), eh1);
        chk("exact_floor8", int'(ex0), eex);
        chk("exact_round8", int'(ex1), eex);
        chk("ov_round8", int'(ov1), 1);
    endtask

    task automatic run12(input int a, input int b, input int eh2, input int eh3, input int eex);
        int n;
        start(1'b1, a, b);
        wait_out(1'b1, n);
        chk("lat12", n, 14);
        chk("hyp_round12", int'(h2), eh2);
        chk("hyp_floor12", int'(h3), eh3);
        chk("exact12", int'(ex2), eex);
        chk("exact_floor12", int'(ex3), eex);
        chk("ov_floor12", int'(ov3), 1);
    endtask

    initial begin
        int n;
        clk = 1'b0; rst_n = 1'b0; ena = 1'b1; out_ready = 1'b1;
        iv8 = 1'b0; x8 = 8'd0; y8 = 8'd0;
        iv12 = 1'b0; x12 = 12'd0; y12 = 12'd0;

        @(negedge clk);
        chk("rst_in_ready", int'(ir0), 0);
        chk("rst_in_ready12", int'(ir2), 0);
        chk("rst_out_valid", int'(ov0), 0);
        chk("rst_hyp", int'(h0), 0);
        chk("rst_exact", int'(ex0), 0);
        chk("rst_busy", int'(bz0 | bz1 | bz2 | bz3), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", int'(ir0 & ir1 & ir3), 1);

        run8(3, 4, 5, 5, 1);
        run8(6, 8, 10, 10, 1);
        run8(10, 10, 14, 14, 0);
        run8(12, 16, 20, 20, 1);
        run8(2, 3, 3, 4, 0);
        run8(1, 1, 1, 1, 0);
        run8(255, 255, 360, 361, 0);
        run8(0, 0, 0, 0, 1);
        run8(0, 9, 9, 9, 1);

        // Backpressure: result held while the consumer is not ready
        start(1'b0, 3, 4);
        out_ready = 1'b0;
        wait_out(1'b0, n);
        chk("bp_lat", n, 10);
        iv8 = 1'b1; x8 = 8'd7; y8 = 8'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            chk("bp_out_valid", int'(ov0), 1);
            chk("bp_hyp", int'(h0), 5);
            chk("bp_in_ready", int'(ir0), 0);
        end
        iv8 = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp_consumed", int'(ov0), 0);
        chk("bp_idle", int'(bz0), 0);
        chk("bp_ready_again", int'(ir0), 1);
        chk("bp_hyp_held", int'(h0), 5);

        // Stall during the root iterations
        start(1'b0, 6, 8);
        repeat (4) @(negedge clk);
        ena = 1'b0;
        chk("stall_in_ready", int'(ir0), 0);
        repeat (3) @(negedge clk);
        ena = 1'b1;
        wait_out(1'b0, n);
        chk("stall_lat", n + 7, 13);
        chk("stall_hyp", int'(h0), 10);
        chk("stall_exact", int'(ex0), 1);

        // Asynchronous reset in the middle of a computation
        start(1'b0, 12, 16);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(ov0), 0);
        chk("abort_hyp", int'(h0), 0);
        chk("abort_exact", int'(ex0), 0);
        chk("abort_busy", int'(bz0), 0);
        chk("abort_in_ready", int'(ir0), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", int'(ir0), 1);
        chk("abort_no_valid", int'(ov0), 0);
        run8(3, 4, 5, 5, 1);

        run12(3000, 4000, 5000, 5000, 1);
        run12(4095, 4095, 5791, 5791, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
